// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel/line counters, line/frame pulses and delayed sync/blank.
// Optional colour-bar test pattern output enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_VISIBLE  = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter bit          SYNC_POL   = 1'b1,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] vga_h,
  output logic [10:0] vga_v,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic        hsync_out,
  output logic        vsync_out,
`ifdef VGA_TEST_PATTERN_EN
  output logic [23:0] pattern_rgb,
`endif
  output logic        blank_n_out
);

  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] H_TOTAL  = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] H_LAST   = H_TOTAL - 11'd1;
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] V_TOTAL  = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] V_LAST   = V_TOTAL - 11'd1;
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned PW = 27;
  localparam logic [10:0] BAR_LAST = 11'(H_VISIBLE / 8) - 11'd1;
  localparam logic [PW-1:0] RST_VAL = {24'h000000, 1'b0, ~SYNC_POL, ~SYNC_POL};
`else
  localparam int unsigned PW = 3;
  localparam logic [PW-1:0] RST_VAL = {1'b0, ~SYNC_POL, ~SYNC_POL};
`endif

  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        active_q, active_d;
  logic        line_q, line_d;
  logic        frame_q, frame_d;
  logic        hs_raw_s, vs_raw_s;
  logic [PW-1:0] stage_in_s;
  logic [PW-1:0] stage_out_s;

  // Counter next-state: wrap at TOTAL-1 (>= guards against any out-of-range value)
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (pix_en) begin
      if (h_q >= H_LAST) begin
        h_d    = 11'd0;
        line_d = 1'b1;
        if (v_q >= V_LAST) begin
          v_d     = 11'd0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 11'd1;
        end
      end else begin
        h_d = h_q + 11'd1;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
    active_d = (h_d < H_VIS) && (v_d < V_VIS);
  end

  // Counter and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q      <= 11'd0;
      v_q      <= 11'd0;
      active_q <= 1'b1;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign hs_raw_s = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_raw_s = (v_q >= VS_START) && (v_q < VS_END);

`ifdef VGA_TEST_PATTERN_EN
  logic [10:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [23:0] rgb_raw_s;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      3'd7:    c = 24'h000000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Bar position tracks vga_h with a per-bar pixel counter instead of a divider
  always_comb begin
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (pix_en) begin
      if (h_q >= H_LAST) begin
        bar_cnt_d = 11'd0;
        bar_idx_d = 3'd0;
      end else if (bar_cnt_q >= BAR_LAST) begin
        bar_cnt_d = 11'd0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 11'd1;
      end
    end else begin
      bar_cnt_d = bar_cnt_q;
    end
  end

  // Bar counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bar_cnt_q <= 11'd0;
      bar_idx_q <= 3'd0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  assign rgb_raw_s  = active_q ? bar_color(bar_idx_q) : 24'h000000;
  assign stage_in_s = {rgb_raw_s, active_q, vs_raw_s ^ ~SYNC_POL, hs_raw_s ^ ~SYNC_POL};
  assign pattern_rgb = stage_out_s[26:3];
`else
  assign stage_in_s = {active_q, vs_raw_s ^ ~SYNC_POL, hs_raw_s ^ ~SYNC_POL};
`endif

  // Polarity is applied before the pipe so a cleared stage reads as inactive sync
  generate
    if (PIPE_DELAY == 0) begin : g_nopipe
      assign stage_out_s = stage_in_s;
    end else begin : g_pipe
      logic [PW-1:0] pipe_q [PIPE_DELAY];

      // Delay pipe shifts every clock, independent of pix_en
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < int'(PIPE_DELAY); i++) pipe_q[i] <= RST_VAL;
        end else begin
          pipe_q[0] <= stage_in_s;
          for (int i = 1; i < int'(PIPE_DELAY); i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign stage_out_s = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  assign vga_h       = h_q;
  assign vga_v       = v_q;
  assign active      = active_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign hsync_out   = stage_out_s[0];
  assign vsync_out   = stage_out_s[1];
  assign blank_n_out = stage_out_s[2];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 timing instance plus a tiny-raster instance for full-frame checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset, pix_en, s_reset, s_pix_en;
  logic [10:0] d_h, d_v, s_h, s_v;
  logic d_act, d_ls, d_fs, d_hs, d_vs, d_bn;
  logic s_act, s_ls, s_fs, s_hs, s_vs, s_bn;
`ifdef VGA_TEST_PATTERN_EN
  logic [23:0] d_rgb, s_rgb;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  int ls_cnt, hs_cnt, fs_cnt, vs_cnt;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_h(d_h), .vga_v(d_v), .active(d_act),
    .line_start(d_ls), .frame_start(d_fs),
    .hsync_out(d_hs), .vsync_out(d_vs),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_rgb(d_rgb),
`endif
    .blank_n_out(d_bn)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .PIPE_DELAY(2)
  ) dut_s (
    .clk(clk), .reset(s_reset), .pix_en(s_pix_en),
    .vga_h(s_h), .vga_v(s_v), .active(s_act),
    .line_start(s_ls), .frame_start(s_fs),
    .hsync_out(s_hs), .vsync_out(s_vs),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_rgb(s_rgb),
`endif
    .blank_n_out(s_bn)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; pix_en = 1'b0; s_reset = 1'b1; s_pix_en = 1'b0;
    #2;
    step();
    check("rst_h", 32'(d_h), 32'd0);
    check("rst_v", 32'(d_v), 32'd0);
    check("rst_active", 32'(d_act), 32'd1);
    check("rst_ls", 32'(d_ls), 32'd0);
    check("rst_fs", 32'(d_fs), 32'd0);
    check("rst_hs", 32'(d_hs), 32'd0);
    check("rst_vs", 32'(d_vs), 32'd0);
    check("rst_bn", 32'(d_bn), 32'd0);
    check("s_rst_vs_inactive_low_pol", 32'(s_vs), 32'd1);

    // First line, pix_en steady high
    reset = 1'b0; pix_en = 1'b1; ls_cnt = 0;
    for (int i = 1; i <= 1055; i++) begin
      step();
      if (d_ls) ls_cnt++;
      if (i == 1) check("h_first_step", 32'(d_h), 32'd1);
      if (i == 800) begin
        check("active_800", 32'(d_act), 32'd0);
        check("bn_800", 32'(d_bn), 32'd1);
      end
      if (i == 801) check("bn_801", 32'(d_bn), 32'd0);
      if (i == 840) check("hs_840", 32'(d_hs), 32'd0);
      if (i == 841) check("hs_841", 32'(d_hs), 32'd1);
      if (i == 968) check("hs_968", 32'(d_hs), 32'd1);
      if (i == 969) check("hs_969", 32'(d_hs), 32'd0);
`ifdef VGA_TEST_PATTERN_EN
      if (i == 1)   check("rgb_px0", 32'(d_rgb), 32'h00FFFFFF);
      if (i == 101) check("rgb_px100", 32'(d_rgb), 32'h00FFFF00);
      if (i == 251) check("rgb_px250", 32'(d_rgb), 32'h0000FFFF);
      if (i == 800) check("rgb_px799", 32'(d_rgb), 32'h00000000);
      if (i == 901) check("rgb_px900", 32'(d_rgb), 32'h00000000);
`endif
    end
    check("h_1055", 32'(d_h), 32'd1055);
    check("v_line0", 32'(d_v), 32'd0);
    check("vs_line0", 32'(d_vs), 32'd0);
    check("no_ls_before_wrap", 32'(ls_cnt), 32'd0);
    step();
    check("wrap_h", 32'(d_h), 32'd0);
    check("wrap_v", 32'(d_v), 32'd1);
    check("wrap_ls", 32'(d_ls), 32'd1);
    check("wrap_fs", 32'(d_fs), 32'd0);

    // Second line with pix_en toggling every clock
    ls_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 2112; i++) begin
      pix_en = (i % 2 == 1);
      step();
      if (d_ls) ls_cnt++;
      if (d_hs) hs_cnt++;
      if (i == 0) begin
        check("toggle_hold_h", 32'(d_h), 32'd0);
        check("toggle_ls_cleared", 32'(d_ls), 32'd0);
      end
      if (i == 1) check("toggle_adv_h", 32'(d_h), 32'd1);
    end
    check("toggle_ls_once", 32'(ls_cnt), 32'd1);
    check("toggle_hs_width_clks", 32'(hs_cnt), 32'd256);
    check("toggle_end_h", 32'(d_h), 32'd0);
    check("toggle_end_v", 32'(d_v), 32'd2);

    // Reset in the middle of hsync
    pix_en = 1'b1;
    for (int i = 0; i < 900; i++) step();
    check("pre_rst_h", 32'(d_h), 32'd900);
    check("pre_rst_hs", 32'(d_hs), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_h", 32'(d_h), 32'd0);
    check("mid_rst_v", 32'(d_v), 32'd0);
    check("mid_rst_hs", 32'(d_hs), 32'd0);
    check("mid_rst_vs", 32'(d_vs), 32'd0);
    check("mid_rst_ls", 32'(d_ls), 32'd0);
    check("mid_rst_fs", 32'(d_fs), 32'd0);

    // Full frame on the tiny raster (24 x 8, active-low sync, 2-clk pipe)
    s_reset = 1'b1;
    step();
    s_reset = 1'b0; s_pix_en = 1'b1; fs_cnt = 0; vs_cnt = 0;
    for (int k = 1; k <= 192; k++) begin
      step();
      if (k < 192 && s_fs) fs_cnt++;
      if (!s_vs) vs_cnt++;
      if (k == 20) check("s_hs_20", 32'(s_hs), 32'd0);
      if (k == 23) check("s_hs_23", 32'(s_hs), 32'd1);
    end
    check("s_no_fs_before_wrap", 32'(fs_cnt), 32'd0);
    check("s_vs_low_clks", 32'(vs_cnt), 32'd48);
    check("s_frame_h", 32'(s_h), 32'd0);
    check("s_frame_v", 32'(s_v), 32'd0);
    check("s_frame_fs", 32'(s_fs), 32'd1);
    check("s_frame_ls", 32'(s_ls), 32'd1);
    s_pix_en = 1'b0;
    step();
    check("s_fs_single", 32'(s_fs), 32'd0);
    check("s_hold_h", 32'(s_h), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
